// File: rtl/ika3012_pkg.sv
// Shared widths and the floating-point word layout for the YM3012-style DAC receiver.
package ika3012_pkg;

  localparam int FP_MANT_W  = 10;
  localparam int FP_EXP_W   = 3;
  localparam int PCM_W      = 16;
  localparam int FRAME_BITS = FP_MANT_W + FP_EXP_W;

  typedef struct packed {
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp_word_t;

endpackage

// File: rtl/ika3012_fp2lin.sv
// One-cycle registered converter: 10-bit mantissa / 3-bit exponent word to signed linear PCM.
module ika3012_fp2lin
  import ika3012_pkg::*;
#(
  parameter bit SIGN_INV = 1'b1
) (
  input  logic             i_EMUCLK,
  input  logic             i_MRST,
  input  logic             load,
  input  fp_word_t         word,
  output logic [PCM_W-1:0] pcm,
  output logic             valid
);

  logic [FP_MANT_W-1:0] m;
  logic [PCM_W-1:0]     m_ext;
  logic [FP_EXP_W-1:0]  shamt;
  logic [PCM_W-1:0]     lin;

  always_comb begin
    m     = SIGN_INV ? {~word.mant[FP_MANT_W-1], word.mant[FP_MANT_W-2:0]} : word.mant;
    m_ext = {{(PCM_W-FP_MANT_W){m[FP_MANT_W-1]}}, m};
    shamt = word.exp - 3'd1;
    // A left shift of the sign-extended value is exact: at most 6 places keeps it in 16 bits.
    lin   = (word.exp == '0) ? '0 : (m_ext << shamt);
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      pcm   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= load;
      if (load) pcm <= lin;
    end
  end

endmodule

// File: rtl/ika3012_dac_rx.sv
// SO bitstream deserialiser with SH1/SH2 falling-edge latches feeding two fp-to-linear decoders.
module ika3012_dac_rx
  import ika3012_pkg::*;
#(
  parameter int MIN_BITS = 13,
  parameter bit SIGN_INV = 1'b1
) (
  input  logic             i_EMUCLK,
  input  logic             i_MRST,
  input  logic             i_phi1_NCEN_n,
  input  logic             i_SO,
  input  logic             i_SH1,
  input  logic             i_SH2,
  output logic [PCM_W-1:0] o_L,
  output logic [PCM_W-1:0] o_R,
  output logic             o_L_VALID,
  output logic             o_R_VALID,
  output logic             o_FRAME_ERR
);

  localparam logic [4:0] MIN_CNT = 5'(MIN_BITS);

  logic [FRAME_BITS-1:0] sr, sr_next;
  logic [4:0]            bitcnt;
  logic                  sh1_z, sh2_z;
  logic                  sample, sh1_fall, sh2_fall, frame_ok;
  fp_word_t              raw_l, raw_r;
  logic                  req_l, req_r;
  logic [PCM_W-1:0]      pcm_l, pcm_r;
  logic                  dec_vld_l, dec_vld_r;

  always_comb begin
    sample   = ~i_phi1_NCEN_n;
    sh1_fall = sample & sh1_z & ~i_SH1;
    sh2_fall = sample & sh2_z & ~i_SH2;
    sr_next  = {i_SO, sr[FRAME_BITS-1:1]};
    frame_ok = (bitcnt >= MIN_CNT);
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      sr          <= '0;
      bitcnt      <= '0;
      sh1_z       <= 1'b0;
      sh2_z       <= 1'b0;
      raw_l       <= '0;
      raw_r       <= '0;
      req_l       <= 1'b0;
      req_r       <= 1'b0;
      o_FRAME_ERR <= 1'b0;
    end else begin
      req_l       <= 1'b0;
      req_r       <= 1'b0;
      o_FRAME_ERR <= 1'b0;
      if (sample) begin
        sr    <= sr_next;
        sh1_z <= i_SH1;
        sh2_z <= i_SH2;
        if (sh1_fall || sh2_fall) begin
          // The bit arriving with the strobe also opens the next frame's count.
          bitcnt <= 5'd1;
          if (frame_ok) begin
            if (sh1_fall) raw_l <= fp_word_t'(sr_next);
            if (sh2_fall) raw_r <= fp_word_t'(sr_next);
            req_l <= sh1_fall;
            req_r <= sh2_fall;
          end else begin
            o_FRAME_ERR <= 1'b1;
          end
        end else if (bitcnt != 5'd31) begin
          bitcnt <= bitcnt + 5'd1;
        end
      end
    end
  end

  ika3012_fp2lin #(.SIGN_INV(SIGN_INV)) u_fp2lin_l (
    .i_EMUCLK (i_EMUCLK),
    .i_MRST   (i_MRST),
    .load     (req_l),
    .word     (raw_l),
    .pcm      (pcm_l),
    .valid    (dec_vld_l)
  );

  ika3012_fp2lin #(.SIGN_INV(SIGN_INV)) u_fp2lin_r (
    .i_EMUCLK (i_EMUCLK),
    .i_MRST   (i_MRST),
    .load     (req_r),
    .word     (raw_r),
    .pcm      (pcm_r),
    .valid    (dec_vld_r)
  );

  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      o_L       <= '0;
      o_R       <= '0;
      o_L_VALID <= 1'b0;
      o_R_VALID <= 1'b0;
    end else begin
      o_L_VALID <= dec_vld_l;
      o_R_VALID <= dec_vld_r;
      if (dec_vld_l) o_L <= pcm_l;
      if (dec_vld_r) o_R <= pcm_r;
    end
  end

endmodule

// File: tb/tb_ika3012_dac_rx.sv
// Directed bench for ika3012_dac_rx: framed SO words, strobe edges, short frames and reset.
module tb_ika3012_dac_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        ncen;
  logic        so;
  logic        sh1;
  logic        sh2;
  logic [15:0] o_l, o_r, o_l_tc, o_r_tc;
  logic        l_vld, r_vld, f_err, l_vld_tc, r_vld_tc, f_err_tc;

  int checks = 0;
  int errors = 0;
  int lv_cnt = 0;
  int rv_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  ika3012_dac_rx u_dut (
    .i_EMUCLK      (clk),
    .i_MRST        (rst),
    .i_phi1_NCEN_n (ncen),
    .i_SO          (so),
    .i_SH1         (sh1),
    .i_SH2         (sh2),
    .o_L           (o_l),
    .o_R           (o_r),
    .o_L_VALID     (l_vld),
    .o_R_VALID     (r_vld),
    .o_FRAME_ERR   (f_err)
  );

  ika3012_dac_rx #(.SIGN_INV(1'b0)) u_dut_tc (
    .i_EMUCLK      (clk),
    .i_MRST        (rst),
    .i_phi1_NCEN_n (ncen),
    .i_SO          (so),
    .i_SH1         (sh1),
    .i_SH2         (sh2),
    .o_L           (o_l_tc),
    .o_R           (o_r_tc),
    .o_L_VALID     (l_vld_tc),
    .o_R_VALID     (r_vld_tc),
    .o_FRAME_ERR   (f_err_tc)
  );

  always @(posedge clk) begin
    if (l_vld) lv_cnt <= lv_cnt + 1;
    if (r_vld) rv_cnt <= rv_cnt + 1;
    if (f_err) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk) #1;
  endtask

  // One sample cycle followed by one idle cycle.
  task automatic step(input logic b, input logic s1, input logic s2);
    so = b; sh1 = s1; sh2 = s2; ncen = 1'b0;
    @(posedge clk) #1;
    ncen = 1'b1;
    @(posedge clk) #1;
  endtask

  // Lead-in bits, then D0..D9,E0..E2; the strobe falls on the E2 sample cycle.
  task automatic frame(input logic [2:0] e, input logic [9:0] m, input int nlead,
                       input bit f1, input bit f2);
    logic [12:0] w;
    w = {e, m};
    for (int i = 0; i < nlead; i++) step(1'(i % 2), 1'b1, 1'b1);
    for (int i = 0; i < 13; i++)
      step(w[i], (i == 12 && f1) ? 1'b0 : 1'b1, (i == 12 && f2) ? 1'b0 : 1'b1);
  endtask

  // Frame plus one more cycle: VALID is expected high on return.
  task automatic run(input logic [2:0] e, input logic [9:0] m, input int nlead,
                     input bit f1, input bit f2);
    frame(e, m, nlead, f1, f2);
    idle();
  endtask

  initial begin
    rst = 1'b1; ncen = 1'b1; so = 1'b0; sh1 = 1'b1; sh2 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_o_l", int'(o_l), 0);
    chk("rst_o_r", int'(o_r), 0);
    chk("rst_l_vld", int'(l_vld), 0);
    chk("rst_r_vld", int'(r_vld), 0);
    chk("rst_ferr", int'(f_err), 0);

    // exp=7 mant=0x3FF on SH1 -> 32704, checking latency and single-cycle VALID
    frame(3'd7, 10'h3FF, 3, 1'b1, 1'b0);
    chk("t1_early_vld", int'(l_vld), 0);
    idle();
    chk("t1_vld", int'(l_vld), 1);
    chk("t1_o_l", int'($signed(o_l)), 32704);
    chk("t1_o_r_hold", int'($signed(o_r)), 0);
    chk("t1_r_vld", int'(r_vld), 0);
    idle();
    chk("t1_vld_drop", int'(l_vld), 0);
    chk("t1_o_l_hold", int'($signed(o_l)), 32704);
    chk("t1_lv_cnt", lv_cnt, 1);

    run(3'd7, 10'h000, 3, 1'b0, 1'b1);
    chk("t2_r_vld", int'(r_vld), 1);
    chk("t2_o_r", int'($signed(o_r)), -32768);
    chk("t2_o_l_hold", int'($signed(o_l)), 32704);

    run(3'd3, 10'h201, 3, 1'b0, 1'b1);
    chk("t3_o_r", int'($signed(o_r)), 4);

    run(3'd1, 10'h200, 3, 1'b0, 1'b1);
    chk("t4_r_vld", int'(r_vld), 1);
    chk("t4_o_r", int'($signed(o_r)), 0);

    run(3'd0, 10'h3FF, 3, 1'b1, 1'b0);
    chk("t5_l_vld", int'(l_vld), 1);
    chk("t5_o_l", int'($signed(o_l)), 0);

    run(3'd2, 10'h3FF, 3, 1'b1, 1'b0);
    chk("t6_tc_o_l", int'($signed(o_l_tc)), -2);
    chk("t6_oi_o_l", int'($signed(o_l)), 1022);

    run(3'd4, 10'h280, 3, 1'b1, 1'b1);
    chk("t7_l_vld", int'(l_vld), 1);
    chk("t7_r_vld", int'(r_vld), 1);
    chk("t7_o_l", int'($signed(o_l)), 1024);
    chk("t7_o_r", int'($signed(o_r)), 1024);
    idle();
    chk("t7_lv_cnt", lv_cnt, 4);
    chk("t7_rv_cnt", rv_cnt, 4);
    chk("t7_err_cnt", err_cnt, 0);

    // 8-bit frame: error pulse, no decode
    for (int i = 0; i < 8; i++) step(1'b1, (i == 7) ? 1'b0 : 1'b1, 1'b1);
    repeat (3) idle();
    chk("t8_err_cnt", err_cnt, 1);
    chk("t8_lv_cnt", lv_cnt, 4);
    chk("t8_o_l_hold", int'($signed(o_l)), 1024);

    run(3'd6, 10'h100, 3, 1'b1, 1'b0);
    chk("t9_l_vld", int'(l_vld), 1);
    chk("t9_o_l", int'($signed(o_l)), -8192);

    // Long lead-in drives the bit counter into saturation
    run(3'd2, 10'h205, 30, 1'b1, 1'b0);
    chk("t10_o_l", int'($signed(o_l)), 10);

    // Reset after 6 bits with SH1 held high
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("t11_rst_o_l", int'(o_l), 0);
    chk("t11_rst_o_r", int'(o_r), 0);
    run(3'd5, 10'h3C0, 1, 1'b1, 1'b0);
    chk("t11_o_l", int'($signed(o_l)), 7168);
    idle();
    chk("t11_lv_cnt", lv_cnt, 7);
    chk("t11_rv_cnt", rv_cnt, 4);
    chk("t11_err_cnt", err_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ika3012_dac_rx.md
Name: ika3012_dac_rx

Overview:
- Receiving end of the serial sound output (SO) of the accumulator.
- Emulates the YM3012-style floating-point DAC front end. Deserialises the SO bitstream and latches left/right words on the SH1/SH2 falling edges.
- Converts each 13-bit word (10-bit offset-binary mantissa, 3-bit exponent) to 16-bit signed linear PCM.
- Sits beside the core in the top level and feeds the audio output / mixer path.

Parameters:
- MIN_BITS, 13: minimum number of bits shifted since the last latch for a frame to be accepted.
- SIGN_INV, 1: when 1, mantissa bit 9 is the inverted sign (offset binary). When 0, mantissa is two's complement.

Ports:
- i_EMUCLK  in  1  emulator master clock, single clock domain.
- i_MRST  in  1  synchronous reset, active-high.
- i_phi1_NCEN_n  in  1  bit-sample enable, active low. All shifting and edge detection happen only on i_EMUCLK edges with this low.
- i_SO  in  1  serial sound data, LSB first.
- i_SH1  in  1  left sample-hold strobe; a falling edge latches left.
- i_SH2  in  1  right sample-hold strobe; a falling edge latches right.
- o_L  out  16  left linear PCM, signed.
- o_R  out  16  right linear PCM, signed.
- o_L_VALID  out  1  one-i_EMUCLK pulse when o_L updates.
- o_R_VALID  out  1  one-i_EMUCLK pulse when o_R updates.
- o_FRAME_ERR  out  1  one-i_EMUCLK pulse when a strobe edge arrives with a short frame.

Behaviour:
- Reset (i_MRST=1 at a clock edge):
  - o_L=0, o_R=0; all pulses 0.
  - Shift register 0, bit counter 0.
  - SH1/SH2 history registers set to 0, so no false edge after reset.
  - Reset mid-frame discards partial bits and aborts any pending decode.
- Sample cycle (i_phi1_NCEN_n=0):
  - sr[12:0] <= {i_SO, sr[12:1]}; the newest bit enters the MSB.
  - bitcnt increments and saturates at 31.
  - sh1_z <= i_SH1, sh2_z <= i_SH2.
- Edge detect: in a sample cycle, sh1_fall = sh1_z & ~i_SH1; sh2_fall likewise.
- Frame layout at the edge: sr = {exp[2:0], mant[9:0]}. The last 13 bits received are mant D0..D9 then exp E0..E2; leading don't-care bits have already shifted out.
- Latch (same sample cycle as the edge):
  - If bitcnt >= MIN_BITS, the corresponding raw register captures sr (including the bit arriving this cycle) and a decode request is set.
  - Otherwise no capture and o_FRAME_ERR pulses.
  - Either way bitcnt resets to 0 and the current bit counts as bit 1.
- Simultaneous SH1 and SH2 falls: both raw registers capture the same sr; both VALID pulses fire together; o_FRAME_ERR pulses once if the frame is short.
- Decode, one pipeline register, independent of the enable:
  - m = SIGN_INV ? {~mant[9], mant[8:0]} : mant, treated as signed 10-bit, range -512..511.
  - exp=0: result 0. exp=1..7: result = sign-extend(m) << (exp-1).
  - Range is -32768..32704; no saturation is needed.
- Latency:
  - The decode register loads on the i_EMUCLK edge after the latch edge.
  - o_L/o_R and VALID update on the following edge, i.e. 2 i_EMUCLK cycles after the latching sample cycle.
  - VALID is high for exactly one i_EMUCLK cycle.
- Outputs hold their last value between updates.
- A new edge arriving while a decode is in flight is still captured. This requires edges at least 2 i_EMUCLK apart, which is guaranteed because sample cycles are at least 2 apart.

Decomposition:
- Package ika3012_pkg holds:
  - FP_MANT_W=10, FP_EXP_W=3, PCM_W=16, FRAME_BITS=13 constants.
  - Typedef fp_word_t {exp, mant}.
- Sub-module ika3012_fp2lin: one-cycle registered mantissa/exponent to linear converter, instantiated twice (L, R).
- Parent holds the shift register, bit counter, edge detect, latches and pulse generation.

Test Plan:
- Frame word exp=7, mant=0x3FF, 16 bits, then SH1 fall -> o_L=32704 (0x7FC0), o_L_VALID single pulse 2 clocks later, o_R unchanged.
- Frame exp=7, mant=0x000, then SH2 fall -> o_R=-32768 (0x8000); exp=3, mant=0x201 -> o_R=4; exp=1, mant=0x200 -> 0.
- Frame exp=0, mant=0x3FF -> output 0 with VALID asserted; SIGN_INV=0 build, exp=2, mant=0x3FF -> -2.
- SH1 and SH2 fall in the same sample cycle with exp=4, mant=0x280 -> o_L=o_R=1024, both VALID together.
- Only 8 bits shifted, then SH1 fall -> o_FRAME_ERR pulse, o_L unchanged, no VALID; the next full frame decodes normally.
- Assert i_MRST mid-frame (after 6 bits) -> all outputs 0; with SH1 held at 1 across reset, no edge is detected; the next 13-bit frame decodes correctly.
